division_fija: RTL and testbench



---
 rtl/division_fija.sv | 138 +++++++++++++
 tb/tb_division_fija.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/division_fija.sv
// Sequential signed fixed-point divider (restoring, one quotient bit per clock).
// Shares the Q format and saturation limits of the saturating fixed-point multiplier.
module division_fija #(
    parameter int decim = 16,
    parameter int magn  = 8,
    parameter int N     = decim + magn + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] ResulDiv,
    output logic         done,
    output logic         busy
);

    localparam int DW = N - 1 + decim;
    localparam int CW = $clog2(DW + 1);
    localparam logic [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] SAT_MIN = {1'b1, {(N-2){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, DIV, FIN} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] dq_q, dq_d;
    logic [N-1:0]  rem_q, rem_d;
    logic [N-2:0]  bmag_q, bmag_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          signo_q, signo_d;
    logic [N-1:0]  res_q, res_d;
    logic          done_q, done_d;

    logic [N-1:0]  a_neg, b_neg;
    logic [N-2:0]  a_mag, b_mag;
    logic          a_zero, b_zero;
    logic [N-1:0]  rem_sh, q_mag;
    logic          fits, ovf;

    // Operand decode; the most-negative pattern has a zero magnitude field and counts as zero.
    always_comb begin
        a_neg  = -A;
        b_neg  = -B;
        a_mag  = A[N-1] ? a_neg[N-2:0] : A[N-2:0];
        b_mag  = B[N-1] ? b_neg[N-2:0] : B[N-2:0];
        a_zero = (A[N-2:0] == '0);
        b_zero = (B[N-2:0] == '0);
    end

    // One restoring step; the dividend MSB shifts out of dq while quotient bits shift in.
    always_comb begin
        rem_sh = {rem_q[N-2:0], dq_q[DW-1]};
        fits   = rem_q[N-1] | (rem_sh >= {1'b0, bmag_q});
        ovf    = |dq_q[DW-1:N-1];
        q_mag  = {1'b0, dq_q[N-2:0]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            dq_q    <= '0;
            rem_q   <= '0;
            bmag_q  <= '0;
            cnt_q   <= '0;
            signo_q <= 1'b0;
            res_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dq_q    <= dq_d;
            rem_q   <= rem_d;
            bmag_q  <= bmag_d;
            cnt_q   <= cnt_d;
            signo_q <= signo_d;
            res_q   <= res_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = (a_zero || b_zero) ? FIN : DIV;
            DIV:  if (cnt_q == CW'(1)) state_d = FIN;
            FIN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dq_d    = dq_q;
        rem_d   = rem_q;
        bmag_d  = bmag_q;
        cnt_d   = cnt_q;
        signo_d = signo_q;
        res_d   = res_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    signo_d = A[N-1] ^ B[N-1];
                    bmag_d  = b_mag;
                    rem_d   = '0;
                    cnt_d   = '0;
                    if (a_zero) begin
                        dq_d = '0;
                    end else if (b_zero) begin
                        // An all-ones quotient forces the saturation path in FIN.
                        dq_d = '1;
                    end else begin
                        dq_d  = {a_mag, {decim{1'b0}}};
                        cnt_d = CW'(DW);
                    end
                end
            end
            DIV: begin
                rem_d = fits ? (rem_sh - {1'b0, bmag_q}) : rem_sh;
                dq_d  = {dq_q[DW-2:0], fits};
                cnt_d = cnt_q - CW'(1);
            end
            FIN: begin
                if (ovf)
                    res_d = signo_q ? SAT_MIN : SAT_MAX;
                else
                    res_d = signo_q ? -q_mag : q_mag;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        busy     = (state_q != IDLE);
        done     = done_q;
        ResulDiv = res_q;
    end

endmodule

// File: tb/tb_division_fija.sv
// Bench for division_fija: directed literal cases plus random stimulus checked
// every cycle against an arithmetic reference model.
module tb_division_fija;

    localparam int N        = 25;
    localparam int DEC      = 16;
    localparam int LAT_NORM = 41;
    localparam int LAT_ZERO = 1;
    localparam longint MAXMAG = (64'sd1 <<< (N-1)) - 1;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [N-1:0] A, B, ResulDiv;
    logic         done, busy;

    int n_chk = 0, n_fail = 0, l_chk = 0, l_fail = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    division_fija dut (
        .clk(clk), .reset(reset), .start(start), .A(A), .B(B),
        .ResulDiv(ResulDiv), .done(done), .busy(busy)
    );

    function automatic logic [N-1:0] ref_div(input logic [N-1:0] a, input logic [N-1:0] b);
        longint sa, sb, q;
        logic neg;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        neg = (sa < 0) != (sb < 0);
        if (a[N-2:0] == '0) return '0;
        if (sa < 0) sa = -sa;
        if (sb < 0) sb = -sb;
        if (b[N-2:0] == '0) q = MAXMAG + 1;
        else q = (sa <<< DEC) / sb;
        if (q > MAXMAG) q = MAXMAG;
        return neg ? N'(-q) : N'(q);
    endfunction

    // Model: a countdown to the next result, the pending value, and the held output.
    int           m_left;
    logic [N-1:0] m_pend, m_res;
    logic         m_done;

    always @(posedge clk) begin
        if (reset) begin
            m_left <= 0;
            m_pend <= '0;
            m_res  <= '0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_left == 0) begin
                if (start) begin
                    m_left <= ((A[N-2:0] == '0) || (B[N-2:0] == '0)) ? LAT_ZERO : LAT_NORM;
                    m_pend <= ref_div(A, B);
                end
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_res  <= m_pend;
                    m_done <= 1'b1;
                end
            end
        end
    end

    task automatic cmp(input string nm, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("done", N'(done), N'(m_done));
            cmp("busy", N'(busy), N'(m_left != 0));
            cmp("ResulDiv", ResulDiv, m_res);
        end
    end

    task automatic lit(input string nm, input logic [N-1:0] got, input logic [N-1:0] exp);
        l_chk++;
        if (got !== exp) begin
            l_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Returns on the negedge where done is high, so a following call starts back-to-back.
    task automatic do_div(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] exp, input int elat);
        int lat;
        A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        lit("latency", N'(lat), N'(elat));
        lit("result", ResulDiv, exp);
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done === 1'b1) n++;
        end
    endtask

    function automatic logic [N-1:0] rand_op();
        logic [N-1:0] v;
        case ($urandom_range(0, 7))
            0: v = '0;
            1: v = {1'b1, {(N-1){1'b0}}};
            2: v = N'($urandom_range(1, 255));
            3: v = N'($urandom_range(1, 32'h7FFFF));
            default: v = N'($urandom);
        endcase
        if ($urandom_range(0, 1) == 1) v = -v;
        return v;
    endfunction

    initial begin
        int nd, lat;
        reset = 1'b1; start = 1'b0; A = '0; B = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        lit("reset_res", ResulDiv, '0);
        lit("reset_done", N'(done), '0);
        lit("reset_busy", N'(busy), '0);
        reset = 1'b0;
        @(negedge clk);

        do_div(25'h0030000, 25'h0020000, 25'h0018000, LAT_NORM);
        do_div(25'h1FF0000, 25'h0030000, 25'h1FFAAAB, LAT_NORM);
        do_div(25'h0010000, 25'h1FD0000, 25'h1FFAAAB, LAT_NORM);
        do_div(25'h1FF0000, 25'h1FD0000, 25'h0005555, LAT_NORM);
        do_div(25'h0C80000, 25'h0008000, 25'h0FFFFFF, LAT_NORM);
        do_div(25'h1380000, 25'h0008000, 25'h1000001, LAT_NORM);
        do_div(25'h0050000, 25'h0000000, 25'h0FFFFFF, LAT_ZERO);
        do_div(25'h1FB0000, 25'h0000000, 25'h1000001, LAT_ZERO);
        do_div(25'h0000000, 25'h0000000, 25'h0000000, LAT_ZERO);
        @(negedge clk);

        // A start (and operand change) while busy must be ignored.
        A = 25'h0030000; B = 25'h0020000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        A = 25'h0C80000; B = 25'h0008000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = 25'h1FB0000; B = 25'h0000000;
        lat = 0;
        while (done !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        lit("ignored_start_result", ResulDiv, 25'h0018000);
        count_dones(45, nd);
        lit("ignored_start_extra_done", N'(nd), '0);

        // Reset in the middle of a division.
        A = 25'h0030000; B = 25'h0020000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        lit("midreset_res", ResulDiv, '0);
        lit("midreset_busy", N'(busy), '0);
        lit("midreset_done", N'(done), '0);
        count_dones(50, nd);
        lit("midreset_no_done", N'(nd), '0);
        do_div(25'h0030000, 25'h0020000, 25'h0018000, LAT_NORM);

        // Random traffic: starts while busy, operand churn and rare resets.
        nd = 0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
            reset = ($urandom_range(0, 999) == 0);
            start = ($urandom_range(0, 3) == 0);
            A = rand_op();
            B = rand_op();
        end
        reset = 1'b0; start = 1'b0;
        repeat (50) @(negedge clk);
        l_chk++;
        if (nd < 50) begin
            l_fail++;
            $display("FAIL random_activity: got %0d results expected at least 50", nd);
        end

        $display("%0d/%0d checks passed", (n_chk + l_chk) - (n_fail + l_fail), n_chk + l_chk);
        $finish;
    end

endmodule
